// File: rtl/uart_pkg.sv
// Shared UART definitions: receive sequencer states, default frame geometry, clog2 helper.
// No logic; latency and backpressure are not applicable.
// No handshake is involved here.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } rx_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_ctrl_if.sv
// Serial line input plus strobe/status outputs of the receive sequencer.
// Wires only; no latency is added.
// The bus has no backpressure: strobes are fire-and-forget.
interface rx_ctrl_if;
  logic rx_in;
  logic baud_tick;
  logic shift_en;
  logic sample_bit;
  logic chk_stop;
  logic stop_bit_in;
  logic rx_busy;
  logic start_err;
  logic rx_done;

  modport master (
    output rx_in, baud_tick,
    input  shift_en, sample_bit, chk_stop, stop_bit_in, rx_busy, start_err, rx_done
  );

  modport slave (
    input  rx_in, baud_tick,
    output shift_en, sample_bit, chk_stop, stop_bit_in, rx_busy, start_err, rx_done
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous, idle-high UART input.
// Latency: two clk cycles. No backpressure; the input is sampled every cycle.
// Both flops reset to 1 so an idle line never looks like a start bit.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/rx_ctrl.sv
// UART receive sequencer: start qualification, mid-bit shift strobes, stop check strobe.
// Latency: every strobe is registered, one clk after the qualifying baud_tick edge.
// No backpressure: downstream SIPO and stop checker must accept every strobe.
module rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input logic      clk,
  input logic      reset,
  rx_ctrl_if.slave bus
);
  localparam int TW = clog2(OVERSAMPLE);
  localparam int BW = clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          need_high_q, need_high_d;
  logic          rx_s;
  logic          shift_q, shift_d;
  logic          sample_q, sample_d;
  logic          chk_q, chk_d;
  logic          stop_q, stop_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx_in),
    .q     (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    busy_d      = busy_q;
    // After a break frame the line must go high again before a new start counts.
    need_high_d = need_high_q && !rx_s;
    shift_d     = 1'b0;
    sample_d    = 1'b0;
    chk_d       = 1'b0;
    stop_d      = 1'b0;
    err_d       = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.baud_tick && !rx_s && !need_high_q) begin
          state_d = START;
          tick_d  = '0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bus.baud_tick) begin
          if (tick_q == TICK_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (bus.baud_tick) begin
          if (tick_q == TICK_END) begin
            shift_d  = 1'b1;
            sample_d = rx_s;
            tick_d   = '0;
            bit_d    = bit_q + BW'(1);
            if (bit_q == BIT_LAST) state_d = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (bus.baud_tick) begin
          if (tick_q == TICK_END) begin
            chk_d       = 1'b1;
            stop_d      = rx_s;
            need_high_d = !rx_s;
            tick_d      = '0;
            state_d     = DONE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      need_high_q <= 1'b0;
      shift_q     <= 1'b0;
      sample_q    <= 1'b0;
      chk_q       <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      need_high_q <= need_high_d;
      shift_q     <= shift_d;
      sample_q    <= sample_d;
      chk_q       <= chk_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign bus.shift_en    = shift_q;
  assign bus.sample_bit  = sample_q;
  assign bus.chk_stop    = chk_q;
  assign bus.stop_bit_in = stop_q;
  assign bus.rx_busy     = busy_q;
  assign bus.start_err   = err_q;
  assign bus.rx_done     = done_q;
endmodule

// File: tb/tb_rx_ctrl.sv
// Self-checking bench for rx_ctrl: directed frames plus random frames against a tick-count model.
module tb_rx_ctrl;
  localparam int N  = 8;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rx_ctrl_if bus ();
  rx_ctrl #(.DATA_BITS(N), .OVERSAMPLE(OS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Baud tick generator: one pulse every tick_div clocks.
  int tick_div = 4;
  int tdiv_cnt = 0;
  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tdiv_cnt >= tick_div - 1) begin
        tdiv_cnt = 0;
        bus.baud_tick = 1'b1;
      end else begin
        tdiv_cnt++;
        bus.baud_tick = 1'b0;
      end
    end
  end

  // Model: frame position is the number of ticks since start detection.
  // Start decided at OS/2, data bit k at OS/2 + k*OS, stop at OS/2 + (N+1)*OS.
  logic p1 = 1'b1, p2 = 1'b1;
  logic m_in_frame = 1'b0, m_done_pend = 1'b0, m_need_high = 1'b0;
  int   m_t = 0;
  logic [N-1:0] m_byte = '0;
  logic e_shift = 0, e_sample = 0, e_chk = 0, e_stop = 0, e_busy = 0, e_err = 0, e_done = 0;

  always @(negedge clk) begin
    logic rxs, nh_old;
    int k;
    e_shift = 0; e_sample = 0; e_chk = 0; e_stop = 0; e_err = 0; e_done = 0;
    if (!reset) begin
      p1 = 1'b1; p2 = 1'b1;
      m_in_frame = 0; m_done_pend = 0; m_need_high = 0; e_busy = 0; m_t = 0;
    end else begin
      rxs = p2; p2 = p1; p1 = bus.rx_in;
      nh_old = m_need_high;
      m_need_high = m_need_high && !rxs;
      if (m_done_pend) begin
        e_done = 1; e_busy = 0; m_done_pend = 0;
      end else if (!m_in_frame) begin
        if (bus.baud_tick && !rxs && !nh_old) begin
          m_in_frame = 1; m_t = 0; e_busy = 1;
        end
      end else if (bus.baud_tick) begin
        m_t++;
        if (m_t == OS / 2) begin
          if (rxs) begin e_err = 1; e_busy = 0; m_in_frame = 0; end
        end else if (m_t > OS / 2 && (m_t - OS / 2) % OS == 0) begin
          k = (m_t - OS / 2) / OS;
          if (k <= N) begin
            e_shift = 1; e_sample = rxs; m_byte[k-1] = rxs;
          end else begin
            e_chk = 1; e_stop = rxs; m_need_high = !rxs;
            m_in_frame = 0; m_done_pend = 1;
          end
        end
      end
    end
  end

  // Observations of the DUT, gathered by the compare process.
  int cyc = 0;
  int o_shift = 0, o_chk = 0, o_err = 0, o_done = 0, o_busy_rise = 0;
  int chk_cyc = 0, done_cyc = 0, err_cyc = 0, busy_rise_cyc = 0;
  logic o_stop = 1'b0, prev_busy = 1'b0;
  logic [N-1:0] o_byte = '0;
  int shift_cyc[$];
  logic [N-1:0] o_frames[$];

  initial begin
    wait (reset === 1'b1);
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      chk("shift_en", bus.shift_en, e_shift);
      chk("chk_stop", bus.chk_stop, e_chk);
      chk("rx_busy", bus.rx_busy, e_busy);
      chk("start_err", bus.start_err, e_err);
      chk("rx_done", bus.rx_done, e_done);
      if (e_shift) chk("sample_bit", bus.sample_bit, e_sample);
      if (e_chk) chk("stop_bit_in", bus.stop_bit_in, e_stop);
      if (bus.shift_en === 1'b1) begin
        o_shift++;
        o_byte = {bus.sample_bit, o_byte[N-1:1]};
        shift_cyc.push_back(cyc);
      end
      if (bus.chk_stop === 1'b1) begin
        o_chk++; chk_cyc = cyc; o_stop = bus.stop_bit_in; o_frames.push_back(o_byte);
      end
      if (bus.rx_done === 1'b1) begin o_done++; done_cyc = cyc; end
      if (bus.start_err === 1'b1) begin o_err++; err_cyc = cyc; end
      if (bus.rx_busy === 1'b1 && !prev_busy) begin o_busy_rise++; busy_rise_cyc = cyc; end
      prev_busy = bus.rx_busy;
    end
  end

  task automatic clr_obs();
    o_shift = 0; o_chk = 0; o_err = 0; o_done = 0; o_busy_rise = 0;
    shift_cyc.delete();
    o_frames.delete();
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (bus.baud_tick !== 1'b1) @(posedge clk);
    end
    #2;
  endtask

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic stop_lvl);
    bus.rx_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < N; i++) begin
      bus.rx_in = d[i];
      wait_ticks(OS);
    end
    bus.rx_in = stop_lvl;
    wait_ticks(OS);
    bus.rx_in = 1'b1;
  endtask

  initial begin
    #900_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] d;
    logic st, gl;
    int gap;
    bus.rx_in = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.shift_en, bus.sample_bit, bus.chk_stop, bus.stop_bit_in,
                          bus.rx_busy, bus.start_err, bus.rx_done}, 0);
    #1;
    reset = 1'b1;

    // Idle line for 200 clk.
    clr_obs();
    repeat (200) @(posedge clk);
    #2;
    chk("idle_activity", o_shift + o_chk + o_err + o_done + o_busy_rise, 0);

    // 0xA5, good stop.
    clr_obs();
    send_frame(8'hA5, 1'b1);
    idle(12);
    chk("a5_shifts", o_shift, 8);
    chk("a5_data", o_byte, 8'hA5);
    chk("a5_model_data", m_byte, 8'hA5);
    chk("a5_chk_count", o_chk, 1);
    chk("a5_stop_level", o_stop, 1);
    chk("a5_done_count", o_done, 1);
    chk("a5_done_after_chk", done_cyc - chk_cyc, 1);
    for (int i = 1; i < shift_cyc.size(); i++)
      chk("a5_shift_gap", shift_cyc[i] - shift_cyc[i-1], OS * 4);

    // 0x3C, stop level low.
    clr_obs();
    send_frame(8'h3C, 1'b0);
    idle(12);
    chk("3c_shifts", o_shift, 8);
    chk("3c_data", o_byte, 8'h3C);
    chk("3c_stop_level", o_stop, 0);
    chk("3c_done_count", o_done, 1);

    // Glitch of 5 ticks: false start.
    clr_obs();
    bus.rx_in = 1'b0;
    wait_ticks(5);
    bus.rx_in = 1'b1;
    wait_ticks(12);
    chk("glitch_err_count", o_err, 1);
    chk("glitch_shifts", o_shift, 0);
    chk("glitch_busy_end", bus.rx_busy, 0);
    chk("glitch_err_delay", err_cyc - busy_rise_cyc, (OS / 2) * 4);

    // Reset after the third data bit of 0xF0.
    clr_obs();
    d = 8'hF0;
    bus.rx_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 2; i++) begin
      bus.rx_in = d[i];
      wait_ticks(OS);
    end
    bus.rx_in = d[2];
    for (int i = 0; i < 500 && o_shift < 3; i++) begin
      @(posedge clk);
      #2;
    end
    chk("rst_third_shift_seen", o_shift, 3);
    reset = 1'b0;
    bus.rx_in = 1'b1;
    #1;
    chk("rst_immediate", {bus.shift_en, bus.sample_bit, bus.chk_stop, bus.stop_bit_in,
                          bus.rx_busy, bus.start_err, bus.rx_done}, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    idle(20);
    chk("rst_no_partial", o_shift + o_chk, 3);
    clr_obs();
    send_frame(8'h55, 1'b1);
    idle(12);
    chk("55_shifts", o_shift, 8);
    chk("55_chk_count", o_chk, 1);
    chk("55_data", o_byte, 8'h55);

    // Back-to-back 0x01, 0x80.
    clr_obs();
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    idle(12);
    chk("b2b_shifts", o_shift, 16);
    chk("b2b_chk_count", o_chk, 2);
    chk("b2b_done_count", o_done, 2);
    chk("b2b_err_count", o_err, 0);
    if (o_frames.size() == 2) begin
      chk("b2b_frame0", o_frames[0], 8'h01);
      chk("b2b_frame1", o_frames[1], 8'h80);
    end else begin
      chk("b2b_frame_count", o_frames.size(), 2);
    end

    // Break: line low for well over a frame.
    clr_obs();
    bus.rx_in = 1'b0;
    wait_ticks(OS * (N + 2) + 30);
    idle(20);
    chk("brk_starts", o_busy_rise, 1);
    chk("brk_shifts", o_shift, 8);
    chk("brk_data", o_byte, 0);
    chk("brk_stop_level", o_stop, 0);
    chk("brk_err_count", o_err, 0);

    // Random frames, tick rates, gaps and glitches.
    for (int f = 0; f < 12; f++) begin
      d = N'($urandom);
      st = ($urandom_range(0, 3) != 0);
      gl = ($urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 10);
      tick_div = $urandom_range(2, 5);
      idle(4);
      clr_obs();
      if (gl) begin
        bus.rx_in = 1'b0;
        wait_ticks($urandom_range(1, 6));
        idle(12);
      end
      send_frame(d, st);
      idle(12 + gap);
      chk("rnd_err_count", o_err, {31'd0, gl});
      chk("rnd_chk_count", o_chk, 1);
      if (o_frames.size() == 1) chk("rnd_data", o_frames[0], d);
      chk("rnd_stop_level", o_stop, {31'd0, st});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
